pin_in_cond: RTL and testbench

- Input-direction conditioner for the 32 bidirectional I/O pads: the receive path that complements the pad output drivers.
- Synchronises raw pad levels into the clk_cog domain and applies a per-pin programmable glitch filter.
- Generates one-cycle rise/fall pulses per pin.
- Flags sticky contention when a driven pin reads back a different level than the value being driven.
- Output pin_in feeds the core's pin input bus in place of the raw pads.

---
 rtl/pin_pkg.sv | 27 ++
 rtl/pin_in_cond_if.sv | 41 ++++
 rtl/pin_in_cond_bit.sv | 110 +++++++++++
 rtl/pin_in_cond.sv | 41 ++++
 tb/tb_pin_in_cond.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pin_pkg.sv
// Shared constants and helpers for the pad input conditioner.
//   PINS_DEF      default number of conditioned pins
//   SYNC_DEF      default synchroniser depth
//   FILT_W_DEF    default width of filter length / filter counter
//   CONT_CYC_DEF  default mismatch cycles before contention is flagged
//   filt_act_e    per-cycle action taken by a pin's glitch filter
//   cont_w()      width of the contention mismatch counter
package pin_pkg;

  localparam int unsigned PINS_DEF     = 32;
  localparam int unsigned SYNC_DEF     = 2;
  localparam int unsigned FILT_W_DEF   = 4;
  localparam int unsigned CONT_CYC_DEF = 8;

  typedef enum logic [1:0] {
    FILT_BYPASS,
    FILT_HOLD,
    FILT_COUNT,
    FILT_FLIP
  } filt_act_e;

  // Counter must be able to hold CONT_CYC itself (saturation value).
  function automatic int unsigned cont_w(input int unsigned cyc);
    return $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/pin_in_cond_if.sv
// Pin-side bus of the input conditioner.
//   io_in     raw pad levels (asynchronous)
//   pin_dir   1 = pin driven by the core
//   pin_out   value driven onto the pin
//   filt_en   per-pin glitch filter enable
//   filt_len  shared filter length, 0 = bypass
//   cont_clr  per-pin contention flag clear
//   pin_in    conditioned pin level
//   pin_rise  one-cycle 0->1 pulse
//   pin_fall  one-cycle 1->0 pulse
//   pin_cont  sticky contention flag
// master: core / pad side driving controls; slave: the conditioner.
interface pin_in_cond_if
  import pin_pkg::*;
#(
  parameter int unsigned PINS   = PINS_DEF,
  parameter int unsigned FILT_W = FILT_W_DEF
);

  logic [PINS-1:0]   io_in;
  logic [PINS-1:0]   pin_dir;
  logic [PINS-1:0]   pin_out;
  logic [PINS-1:0]   filt_en;
  logic [FILT_W-1:0] filt_len;
  logic [PINS-1:0]   cont_clr;
  logic [PINS-1:0]   pin_in;
  logic [PINS-1:0]   pin_rise;
  logic [PINS-1:0]   pin_fall;
  logic [PINS-1:0]   pin_cont;

  modport master (
    output io_in, pin_dir, pin_out, filt_en, filt_len, cont_clr,
    input  pin_in, pin_rise, pin_fall, pin_cont
  );

  modport slave (
    input  io_in, pin_dir, pin_out, filt_en, filt_len, cont_clr,
    output pin_in, pin_rise, pin_fall, pin_cont
  );

endinterface

// File: rtl/pin_in_cond_bit.sv
// One pin of the input conditioner: synchroniser, glitch filter,
// edge detect and read-back contention flag.
//   clk_cog, res  clock and synchronous active-high reset
//   io_in         raw pad level
//   pin_dir       pin driven by the core
//   pin_out       driven value
//   filt_en       filter enable for this pin
//   filt_len      filter length (0 = bypass)
//   cont_clr      clear contention flag
//   pin_in        filtered level
//   pin_rise      0->1 pulse, pin_fall 1->0 pulse
//   pin_cont      sticky contention flag
module pin_in_cond_bit
  import pin_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_DEF,
  parameter int unsigned FILT_W      = FILT_W_DEF,
  parameter int unsigned CONT_CYC    = CONT_CYC_DEF
) (
  input  logic              clk_cog,
  input  logic              res,
  input  logic              io_in,
  input  logic              pin_dir,
  input  logic              pin_out,
  input  logic              filt_en,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              cont_clr,
  output logic              pin_in,
  output logic              pin_rise,
  output logic              pin_fall,
  output logic              pin_cont
);

  localparam int unsigned     CW    = cont_w(CONT_CYC);
  localparam logic [CW-1:0]   M_MAX = CW'(CONT_CYC);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl;
  logic                   prev;
  logic [FILT_W-1:0]      cnt;
  logic [FILT_W-1:0]      lim;
  logic [CW-1:0]          mis;
  logic                   cont;
  logic                   s;
  filt_act_e              act;

  assign s = sync_q[SYNC_STAGES-1];

  // Compare against filt_len-1 with >= so a counter already past a newly
  // shortened limit flips on the next mismatching cycle.
  always_comb begin
    lim = filt_len - FILT_W'(1);
    act = FILT_HOLD;
    if (!filt_en || (filt_len == '0)) begin
      act = FILT_BYPASS;
    end else if (s == lvl) begin
      act = FILT_HOLD;
    end else if (cnt >= lim) begin
      act = FILT_FLIP;
    end else begin
      act = FILT_COUNT;
    end
  end

  always_ff @(posedge clk_cog) begin
    if (res) begin
      sync_q <= '0;
      lvl    <= 1'b0;
      prev   <= 1'b0;
      cnt    <= '0;
      mis    <= '0;
      cont   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], io_in};
      prev   <= lvl;

      case (act)
        FILT_BYPASS: begin
          lvl <= s;
          cnt <= '0;
        end
        FILT_FLIP: begin
          lvl <= s;
          cnt <= '0;
        end
        FILT_COUNT: cnt <= cnt + FILT_W'(1);
        default:    cnt <= '0;
      endcase

      if (pin_dir && (lvl != pin_out)) begin
        if (mis != M_MAX) mis <= mis + CW'(1);
      end else begin
        mis <= '0;
      end

      // Set has priority over a simultaneous clear.
      if (mis == M_MAX) begin
        cont <= 1'b1;
      end else if (cont_clr) begin
        cont <= 1'b0;
      end
    end
  end

  assign pin_in   = lvl;
  assign pin_rise = lvl & ~prev;
  assign pin_fall = ~lvl & prev;
  assign pin_cont = cont;

endmodule

// File: rtl/pin_in_cond.sv
// Input-direction conditioner for the bidirectional I/O pads.
// Synchronises, filters and edge-detects every pad and flags contention
// between driven and read-back levels.
//   clk_cog  core clock
//   res      synchronous reset, active high
//   bus      pin_in_cond_if slave modport (pad, control and result vectors)
module pin_in_cond
  import pin_pkg::*;
#(
  parameter int unsigned PINS        = PINS_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_DEF,
  parameter int unsigned FILT_W      = FILT_W_DEF,
  parameter int unsigned CONT_CYC    = CONT_CYC_DEF
) (
  input  logic          clk_cog,
  input  logic          res,
  pin_in_cond_if.slave  bus
);

  for (genvar i = 0; i < PINS; i++) begin : g_pin
    pin_in_cond_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W),
      .CONT_CYC    (CONT_CYC)
    ) u_bit (
      .clk_cog  (clk_cog),
      .res      (res),
      .io_in    (bus.io_in[i]),
      .pin_dir  (bus.pin_dir[i]),
      .pin_out  (bus.pin_out[i]),
      .filt_en  (bus.filt_en[i]),
      .filt_len (bus.filt_len),
      .cont_clr (bus.cont_clr[i]),
      .pin_in   (bus.pin_in[i]),
      .pin_rise (bus.pin_rise[i]),
      .pin_fall (bus.pin_fall[i]),
      .pin_cont (bus.pin_cont[i])
    );
  end

endmodule

// File: tb/tb_pin_in_cond.sv
// Scoreboard bench for pin_in_cond: expected bit values are queued with the
// edge number at which they must hold, and checked 1 time unit after it.
module tb_pin_in_cond;

  localparam int unsigned PINS   = 32;
  localparam int unsigned FILT_W = 4;

  localparam int SIG_IN   = 0;
  localparam int SIG_RISE = 1;
  localparam int SIG_FALL = 2;
  localparam int SIG_CONT = 3;

  typedef struct {
    int unsigned at;
    string       tag;
    int          sig;
    int          pin;
    logic        val;
  } exp_t;

  logic        clk = 1'b0;
  logic        res;
  exp_t        sb[$];
  int unsigned edges   = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  pin_in_cond_if #(.PINS(PINS), .FILT_W(FILT_W)) bus ();

  pin_in_cond #(
    .PINS        (PINS),
    .SYNC_STAGES (2),
    .FILT_W      (FILT_W),
    .CONT_CYC    (8)
  ) dut (
    .clk_cog (clk),
    .res     (res),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  function automatic logic sample(input int sig, input int pin);
    case (sig)
      SIG_IN:   return bus.pin_in[pin];
      SIG_RISE: return bus.pin_rise[pin];
      SIG_FALL: return bus.pin_fall[pin];
      default:  return bus.pin_cont[pin];
    endcase
  endfunction

  task automatic push(input int unsigned at, input string tag, input int sig,
                      input int pin, input logic val);
    exp_t e;
    e.at = at; e.tag = tag; e.sig = sig; e.pin = pin; e.val = val;
    sb.push_back(e);
  endtask

  // Output must be 0, 1, 0 on edges at-1, at, at+1.
  task automatic push_pulse(input int unsigned at, input string tag,
                            input int sig, input int pin);
    push(at - 1, tag, sig, pin, 1'b0);
    push(at,     tag, sig, pin, 1'b1);
    push(at + 1, tag, sig, pin, 1'b0);
  endtask

  always begin
    @(posedge clk);
    edges++;
    #1;
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].at == edges) begin
        check_bit($sformatf("%s@%0d", sb[k].tag, edges),
                  sample(sb[k].sig, sb[k].pin), sb[k].val);
        sb.delete(k);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.io_in    = '0;
    bus.pin_dir  = '0;
    bus.pin_out  = '0;
    bus.filt_en  = '0;
    bus.filt_len = '0;
    bus.cont_clr = '0;
  endtask

  task automatic reset_dut();
    res = 1'b1;
    step(1);
    res = 1'b0;
  endtask

  initial begin
    int unsigned e;
    int guard;
    logic lv;

    res = 1'b1;
    clear_inputs();
    step(1);

    // Reset values.
    e = edges;
    foreach (sb[k]) sb.delete(k);
    for (int p = 0; p < 12; p++) begin
      push(e + 1, "rst_in",   SIG_IN,   p, 1'b0);
      push(e + 1, "rst_cont", SIG_CONT, p, 1'b0);
      push(e + 1, "rst_rise", SIG_RISE, p, 1'b0);
      push(e + 2, "rst_fall", SIG_FALL, p, 1'b0);
    end
    reset_dut();

    // Bypass: pad to pin_in in 3 edges, single rise pulse.
    step(2);
    e = edges;
    bus.io_in[0] = 1'b1;
    push(e + 2, "byp_in", SIG_IN, 0, 1'b0);
    push(e + 3, "byp_in", SIG_IN, 0, 1'b1);
    push(e + 4, "byp_in", SIG_IN, 0, 1'b1);
    push_pulse(e + 3, "byp_rise", SIG_RISE, 0);
    push(e + 3, "byp_fall", SIG_FALL, 0, 1'b0);
    step(6);

    // Filter len 4: 3-cycle glitch rejected.
    bus.filt_en[5] = 1'b1;
    bus.filt_len   = 4'd4;
    step(1);
    e = edges;
    bus.io_in[5] = 1'b1;
    for (int unsigned k = 3; k <= 9; k++) begin
      push(e + k, "glitch_in",   SIG_IN,   5, 1'b0);
      push(e + k, "glitch_rise", SIG_RISE, 5, 1'b0);
    end
    step(3);
    bus.io_in[5] = 1'b0;
    step(8);

    // 4-cycle pulse passes: rise 6 edges after input edge, fall 6 after drop.
    e = edges;
    bus.io_in[5] = 1'b1;
    push(e + 5, "filt_in", SIG_IN, 5, 1'b0);
    push(e + 6, "filt_in", SIG_IN, 5, 1'b1);
    push_pulse(e + 6, "filt_rise", SIG_RISE, 5);
    step(4);
    bus.io_in[5] = 1'b0;
    push(e + 9,  "filt_in", SIG_IN, 5, 1'b1);
    push(e + 10, "filt_in", SIG_IN, 5, 1'b0);
    push_pulse(e + 10, "filt_fall", SIG_FALL, 5);
    push(e + 10, "filt_rise", SIG_RISE, 5, 1'b0);
    step(10);

    // filt_len shortened 10 -> 2 while the counter sits at 6.
    clear_inputs();
    reset_dut();
    bus.filt_en[5] = 1'b1;
    bus.filt_len   = 4'd10;
    step(1);
    e = edges;
    bus.io_in[5] = 1'b1;
    push(e + 8, "shrink_in", SIG_IN, 5, 1'b0);
    push(e + 9, "shrink_in", SIG_IN, 5, 1'b1);
    step(8);
    bus.filt_len = 4'd2;
    step(3);

    // Contention: driven 1, pad held 0.
    clear_inputs();
    reset_dut();
    e = edges;
    bus.pin_dir[7] = 1'b1;
    bus.pin_out[7] = 1'b1;
    push(e + 8,  "cont_set", SIG_CONT, 7, 1'b0);
    push(e + 9,  "cont_set", SIG_CONT, 7, 1'b1);
    push(e + 11, "cont_setwins", SIG_CONT, 7, 1'b1);
    push(e + 12, "cont_setwins", SIG_CONT, 7, 1'b1);
    push(e + 13, "cont_setwins", SIG_CONT, 7, 1'b1);
    push(e + 14, "cont_clr", SIG_CONT, 7, 1'b0);
    step(10);
    bus.cont_clr[7] = 1'b1;
    step(2);
    bus.pin_out[7] = 1'b0;
    step(2);
    bus.cont_clr[7] = 1'b0;
    step(2);

    // Normal output toggling with pad following never flags.
    clear_inputs();
    reset_dut();
    bus.pin_dir[7] = 1'b1;
    step(2);
    lv = 1'b0;
    for (int k = 0; k < 5; k++) begin
      e  = edges;
      lv = ~lv;
      bus.pin_out[7] = lv;
      bus.io_in[7]   = lv;
      push(e + 2,  "tog_in",   SIG_IN,   7, ~lv);
      push(e + 3,  "tog_in",   SIG_IN,   7, lv);
      push(e + 12, "tog_cont", SIG_CONT, 7, 1'b0);
      push(e + 19, "tog_cont", SIG_CONT, 7, 1'b0);
      step(20);
    end

    // Reset in the middle of a long filter count with contention set.
    clear_inputs();
    reset_dut();
    e = edges;
    bus.filt_en[9] = 1'b1;
    bus.filt_len   = 4'd15;
    bus.pin_dir[9] = 1'b1;
    bus.pin_out[9] = 1'b1;
    bus.io_in[9]   = 1'b1;
    push(e + 8,  "mid_cont",  SIG_CONT, 9, 1'b0);
    push(e + 9,  "mid_cont",  SIG_CONT, 9, 1'b1);
    push(e + 12, "mid_in",    SIG_IN,   9, 1'b0);
    push(e + 13, "mid_rst_in",   SIG_IN,   9, 1'b0);
    push(e + 13, "mid_rst_cont", SIG_CONT, 9, 1'b0);
    push(e + 13, "mid_rst_rise", SIG_RISE, 9, 1'b0);
    push(e + 14, "mid_rst_rise", SIG_RISE, 9, 1'b0);
    push(e + 29, "mid_rel_in",   SIG_IN,   9, 1'b0);
    push(e + 30, "mid_rel_in",   SIG_IN,   9, 1'b1);
    push_pulse(e + 30, "mid_rel_rise", SIG_RISE, 9);
    step(12);
    res = 1'b1;
    step(1);
    res = 1'b0;
    bus.pin_dir[9] = 1'b0;
    step(20);

    guard = 0;
    while (sb.size() != 0 && guard < 500) begin
      step(1);
      guard++;
    end
    foreach (sb[k]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: never checked, expected %b at edge %0d", sb[k].tag, sb[k].val, sb[k].at);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
